// File: rtl/seq_pkg.sv
// Shared types for the serial sequence-detector datapath: serializer FSM states,
// the default idle line level, and the detector's state encodings.
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

  // Detector progress through the 110011 pattern (number of pattern bits matched)
  typedef enum logic [2:0] {
    DET_S0 = 3'd0,
    DET_S1 = 3'd1,
    DET_S2 = 3'd2,
    DET_S3 = 3'd3,
    DET_S4 = 3'd4,
    DET_S5 = 3'd5
  } det_state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feed stage for the sequence detector: valid/ready word input,
// one bit per clock on x. Define SER_LSB_FIRST_EN for LSB-first order (default MSB-first).
module bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  ser_state_t       state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             accept_s;
  logic             shifting_s;
  logic             last_s;

  assign shifting_s = (state_r == SER_SHIFT);
  assign last_s     = shifting_s && (cnt_r == {CW{1'b0}});
  assign in_ready   = !reset && (!shifting_s || last_s);
  assign accept_s   = in_valid && in_ready;
  assign busy       = shifting_s;
  assign x_valid    = shifting_s;
  assign x_last     = last_s;

  // Serial output bit selection; idle fill keeps the detector on a non-matching level
`ifdef SER_LSB_FIRST_EN
  assign x = shifting_s ? shreg_r[0] : IDLE_LEVEL;
`else
  assign x = shifting_s ? shreg_r[WIDTH-1] : IDLE_LEVEL;
`endif

  // Next-state logic: a load on the last bit wins over the return to idle
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    if (accept_s) begin
      state_s = SER_SHIFT;
      shreg_s = in_data;
      cnt_s   = CW'(WIDTH - 1);
    end else begin
      case (state_r)
        SER_SHIFT: begin
`ifdef SER_LSB_FIRST_EN
          shreg_s = shreg_r >> 1;
`else
          shreg_s = shreg_r << 1;
`endif
          cnt_s = cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            state_s = SER_IDLE;
          end else begin
            state_s = SER_SHIFT;
          end
        end
        SER_IDLE: begin
          state_s = SER_IDLE;
        end
        default: begin
          state_s = SER_IDLE;
        end
      endcase
    end
  end

  // State, shift register and bit counter; reset discards any word in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SER_IDLE;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: the driver queues expected bits on each accept,
// a negedge monitor pops and compares whenever x_valid is high and checks idle fill otherwise.
module tb_bit_serializer;
  import seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, x, x_valid, x_last, busy;

  logic         in_ready1, x1, x_valid1, x_last1, busy1;
  logic [W-1:0] zero_data = '0;
  logic         zero_valid = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [1:0] exp_q[$];   // {bit, last}

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .x_valid(x_valid), .x_last(x_last), .busy(busy)
  );

  bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b1)) dut_hi (
    .clk(clk), .reset(reset), .in_data(zero_data), .in_valid(zero_valid),
    .in_ready(in_ready1), .x(x1), .x_valid(x_valid1), .x_last(x_last1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
`ifdef SER_LSB_FIRST_EN
      exp_q.push_back({w[i], (i == W - 1) ? 1'b1 : 1'b0});
`else
      exp_q.push_back({w[W-1-i], (i == W - 1) ? 1'b1 : 1'b0});
`endif
    end
  endtask

  // Present a word and hold it until accepted; returns the number of not-ready cycles
  task automatic send(input logic [W-1:0] w, output int waits);
    bit acc;
    waits = 0;
    in_data  = w;
    in_valid = 1'b1;
    acc = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) waits++;
      @(posedge clk);
      #1;
    end
    if (acc) push_word(w);
    else chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      cycles(1);
      t++;
    end
    cycles(1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare every data bit against the scoreboard, idle fill otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_eq_valid", busy, x_valid);
      if (x_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'd1, 32'd0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("x_bit", x, e[1]);
          chk("x_last", x_last, e[0]);
        end
      end else begin
        chk("idle_x", x, 1'b0);
        chk("idle_last", x_last, 1'b0);
        chk("idle_no_gap", exp_q.size(), 0);
      end
    end
  end

  initial begin
    int waits;
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_in_reset", in_ready, 1'b0);
    cycles(2);
    @(negedge clk);
    chk("rst_x", x, 1'b0);
    chk("rst_valid", x_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", in_ready, 1'b1);

    // Idle 20 cycles; high-idle instance must hold x=1
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hi_x", x1, 1'b1);
      chk("idle_hi_valid", x_valid1, 1'b0);
    end
    cycles(1);

    // Single word
    send(8'hCC, waits);
    drain();
    cycles(3);

    // Back-to-back CC then 33, second held while busy
    send(8'hCC, waits);
    send(8'h33, waits);
    chk("b2b_wait", waits, 7);
    drain();

    // Producer holds FF while busy: not ready for 7 cycles
    send(8'h5A, waits);
    send(8'hFF, waits);
    chk("hold_ff_wait", waits, 7);
    drain();
    cycles(2);

    // Reset during the 4th bit of A5
    send(8'hA5, waits);
    cycles(3);
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_in_midrst", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_x", x, 1'b0);
    chk("midrst_valid", x_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rdy", in_ready, 1'b1);
    cycles(1);
    send(8'h0F, waits);
    chk("post_rst_wait", waits, 0);
    drain();

    // in_data changes mid-word must not disturb the word in flight
    send(8'h96, waits);
    in_data = 8'h00;
    cycles(3);
    in_data = 8'hFF;
    drain();
    cycles(3);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
